// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle radix-2 restoring divider.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [DIV_CNT_W-1:0] DivCntEnd = DIV_CNT_W'(DIV_DATA_W);

endpackage

// File: rtl/div_unit.sv
// Multi-cycle divider for DIV/DIVU: one restoring step per cycle, result as
// {remainder, quotient}. Handshake: start_i is held high until ready_o has been seen.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output div_state_t          dbg_state
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W);

  div_state_t            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [2*DATA_W:0]     work, work_nxt;
  logic [DATA_W-1:0]     dvsr, dvsr_nxt;
  logic                  sg, sg_nxt, sgn1, sgn1_nxt, sgn2, sgn2_nxt;
  logic [2*DATA_W-1:0]   result_nxt;
  logic                  ready_nxt;
  logic [DATA_W:0]       sub_t;
  logic [DATA_W-1:0]     abs_a, abs_b, q_fix, r_fix;

  assign sub_t = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, dvsr};
  assign abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    work_nxt   = work;
    dvsr_nxt   = dvsr;
    sg_nxt     = sg;
    sgn1_nxt   = sgn1;
    sgn2_nxt   = sgn2;
    result_nxt = result_o;
    ready_nxt  = ready_o;
    q_fix      = work[DATA_W-1:0];
    r_fix      = work[2*DATA_W:DATA_W+1];
    case (state)
      DivFree: begin
        ready_nxt  = DivResultNotReady;
        result_nxt = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = DivByZero;
          end else begin
            state_nxt = DivOn;
            cnt_nxt   = '0;
            work_nxt  = {{DATA_W{1'b0}}, abs_a, 1'b0};
            dvsr_nxt  = abs_b;
            sg_nxt    = signed_div_i;
            sgn1_nxt  = opdata1_i[DATA_W-1];
            sgn2_nxt  = opdata2_i[DATA_W-1];
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_nxt = DivFree;
        end else begin
          work_nxt   = '0;
          state_nxt  = DivEnd;
          result_nxt = '0;
          ready_nxt  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_nxt  = DivFree;
          cnt_nxt    = '0;
          ready_nxt  = DivResultNotReady;
          result_nxt = '0;
        end else if (cnt != CntLast) begin
          // Borrow out of the trial subtraction means the divisor did not fit.
          if (sub_t[DATA_W]) work_nxt = {work[2*DATA_W-1:0], 1'b0};
          else               work_nxt = {sub_t[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          if (sg && (sgn1 ^ sgn2)) q_fix = -work[DATA_W-1:0];
          if (sg && sgn1)          r_fix = -work[2*DATA_W:DATA_W+1];
          result_nxt = {r_fix, q_fix};
          ready_nxt  = DivResultReady;
          state_nxt  = DivEnd;
          cnt_nxt    = '0;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_nxt  = DivFree;
          ready_nxt  = DivResultNotReady;
          result_nxt = '0;
        end
      end
      default: state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      work     <= '0;
      dvsr     <= '0;
      sg       <= 1'b0;
      sgn1     <= 1'b0;
      sgn2     <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      work     <= work_nxt;
      dvsr     <= dvsr_nxt;
      sg       <= sg_nxt;
      sgn1     <= sgn1_nxt;
      sgn2     <= sgn2_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  div_state_t  dbg_state;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic sidesteps the MIN/-1 overflow; SV division
  // truncates toward zero and the remainder follows the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // One full transaction: accept, wait for ready, check latency and result,
  // hold start a little, drop it and check the outputs clear.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input string tag);
    int k;
    int exp_lat;
    logic [63:0] exp;
    exp_q.push_back(ref_div(sg, a, b));
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    k = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      k++;
      #1;
      // Operands are free to change once accepted.
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
      if (ready_o) break;
    end
    exp = exp_q.pop_front();
    if (!ready_o) begin
      check({tag, "_timeout"}, 64'(ready_o), 64'd1);
    end else begin
      check({tag, "_lat"}, 64'(k - 1), 64'(exp_lat));
      check({tag, "_res"}, result_o, exp);
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_clr"}, {63'(result_o), ready_o}, 64'd0);
    end
  endtask

  initial begin
    logic seen_ready;
    logic [31:0] ra, rb;
    logic rs;

    // Reset values while rst is held low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {result_o[62:0], ready_o}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(DivFree));
    @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 32'd7, 32'd2, "u7_2");
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, "sm7_2");
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, "s7_m2");
    run_div(1'b1, 32'd1234, 32'd0, "sdz");
    run_div(1'b0, 32'hDEADBEEF, 32'd0, "udz");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "sovf");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, "umax");

    // Flush at cnt=10: no result may appear, then a fresh division works.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd500;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_state", 64'(dbg_state), 64'(DivFree));
    @(negedge clk);
    annul_i = 1'b0;
    seen_ready = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen_ready = 1'b1;
    end
    check("annul_noready", 64'(seen_ready), 64'd0);
    run_div(1'b0, 32'd100, 32'd7, "after_annul");

    // Asynchronous reset mid-division, away from any clock edge.
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i = 32'd99;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_on_out", {result_o[62:0], ready_o}, 64'd0);
    check("arst_on_state", 64'(dbg_state), 64'(DivFree));
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd50;
    opdata2_i = 32'd0;
    start_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_end_pre", 64'(ready_o), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_end_out", {result_o[62:0], ready_o}, 64'd0);
    check("arst_end_state", 64'(dbg_state), 64'(DivFree));
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, "post_rst");

    // Random operands with a mix of signs, small divisors and zeros.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_div(rs, ra, rb, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
